// File: rtl/ddr2_cal_rd_seq_pkg.sv
// Shared DDR2 calibration read-sequencer definitions.
// Holds the FSM state encodings (also visible on dbg_state) and the widths
// of the burst, wait and attempt counters used by ddr2_cal_rd_seq.
package ddr2_cal_rd_seq_pkg;

    localparam int unsigned BURST_CNT_W = 4;
    localparam int unsigned WAIT_CNT_W  = 8;
    localparam int unsigned ATTEMPT_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } cal_state_t;

endpackage

// File: rtl/ddr2_cal_rd_seq.sv
// DDR2 pattern-calibration read sequencer.
// Issues calibration read bursts on ctrl_rden, waits for the pattern-compare
// result and retries up to MAX_ATTEMPTS times. Once calibrated (DONE) it
// passes user reads through to ctrl_rden with one cycle of latency.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   cal_start      in   start/restart calibration (ignored while busy)
//   comp_done      in   all byte lanes finished pattern compare
//   comp_error     in   any byte lane reported a compare error
//   cal_first_loop in   low for one cycle when a second read is needed
//   user_rden      in   user read request (honoured only in DONE)
//   ctrl_rden      out  registered read enable to the read datapath
//   user_rd_gnt    out  user read accepted this cycle
//   cal_busy       out  calibration in progress (ISSUE/WAIT/CHECK)
//   cal_ok         out  calibration succeeded (DONE)
//   cal_fail       out  calibration failed (FAIL)
//   attempt_cnt    out  calibration reads issued in the current run
//   dbg_state      out  current FSM state encoding
module ddr2_cal_rd_seq
    import ddr2_cal_rd_seq_pkg::*;
#(
    parameter int unsigned BURST_LEN    = 2,
    parameter int unsigned RD_GAP       = 32,
    parameter int unsigned MAX_ATTEMPTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cal_start,
    input  logic       comp_done,
    input  logic       comp_error,
    input  logic       cal_first_loop,
    input  logic       user_rden,
    output logic       ctrl_rden,
    output logic       user_rd_gnt,
    output logic       cal_busy,
    output logic       cal_ok,
    output logic       cal_fail,
    output logic [1:0] attempt_cnt,
    output logic [2:0] dbg_state
);

    localparam logic [BURST_CNT_W-1:0] BURST_LOAD  = BURST_CNT_W'(BURST_LEN);
    localparam logic [BURST_CNT_W-1:0] BURST_ONE   = BURST_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LOAD   = WAIT_CNT_W'(RD_GAP);
    localparam logic [WAIT_CNT_W-1:0]  WAIT_ONE    = WAIT_CNT_W'(1);
    localparam logic [ATTEMPT_W-1:0]   ATTEMPT_MAX = ATTEMPT_W'(MAX_ATTEMPTS);
    localparam logic [ATTEMPT_W-1:0]   ATTEMPT_ONE = ATTEMPT_W'(1);

    cal_state_t             r_state;
    cal_state_t             w_state_nxt;
    logic [BURST_CNT_W-1:0] r_burst_cnt;
    logic [BURST_CNT_W-1:0] w_burst_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [WAIT_CNT_W-1:0]  w_wait_nxt;
    logic [ATTEMPT_W-1:0]   r_attempt_cnt;
    logic [ATTEMPT_W-1:0]   w_attempt_nxt;
    logic                   r_ctrl_rden;
    logic                   w_rden_nxt;
    logic                   w_gnt;
    logic                   w_can_retry;

    // cal_start takes priority over a simultaneous user read in DONE.
    assign w_gnt       = (r_state == ST_DONE) && user_rden && !cal_start;
    assign w_can_retry = (r_attempt_cnt < ATTEMPT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_burst_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_attempt_cnt <= '0;
            r_ctrl_rden   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_attempt_cnt <= w_attempt_nxt;
            r_ctrl_rden   <= w_rden_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_burst_nxt   = r_burst_cnt;
        w_wait_nxt    = r_wait_cnt;
        w_attempt_nxt = r_attempt_cnt;
        w_rden_nxt    = 1'b0;

        case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (cal_start) begin
                    w_state_nxt   = ST_ISSUE;
                    w_burst_nxt   = BURST_LOAD;
                    w_attempt_nxt = ATTEMPT_ONE;
                end
            end

            // ctrl_rden is registered, so the burst lags ISSUE entry by one
            // cycle and ISSUE lasts BURST_LEN+1 cycles.
            ST_ISSUE: begin
                if (r_burst_cnt != '0) begin
                    w_rden_nxt  = 1'b1;
                    w_burst_nxt = r_burst_cnt - BURST_ONE;
                end else begin
                    w_state_nxt = ST_WAIT;
                    w_wait_nxt  = WAIT_LOAD;
                end
            end

            ST_WAIT: begin
                if (r_wait_cnt != '0) begin
                    w_wait_nxt = r_wait_cnt - WAIT_ONE;
                end
                if (comp_done) begin
                    w_state_nxt = ST_DONE;
                end else if (comp_error) begin
                    w_state_nxt = ST_FAIL;
                end else if (!cal_first_loop && w_can_retry) begin
                    w_state_nxt   = ST_ISSUE;
                    w_burst_nxt   = BURST_LOAD;
                    w_attempt_nxt = r_attempt_cnt + ATTEMPT_ONE;
                end else if (r_wait_cnt <= WAIT_ONE) begin
                    w_state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (comp_done) begin
                    w_state_nxt = ST_DONE;
                end else if (w_can_retry) begin
                    w_state_nxt   = ST_ISSUE;
                    w_burst_nxt   = BURST_LOAD;
                    w_attempt_nxt = r_attempt_cnt + ATTEMPT_ONE;
                end else begin
                    w_state_nxt = ST_FAIL;
                end
            end

            ST_DONE: begin
                w_rden_nxt = w_gnt;
                if (cal_start) begin
                    w_state_nxt   = ST_ISSUE;
                    w_burst_nxt   = BURST_LOAD;
                    w_attempt_nxt = ATTEMPT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ctrl_rden   = r_ctrl_rden;
    assign user_rd_gnt = w_gnt;
    assign cal_busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                         (r_state == ST_CHECK);
    assign cal_ok      = (r_state == ST_DONE);
    assign cal_fail    = (r_state == ST_FAIL);
    assign attempt_cnt = r_attempt_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ddr2_cal_rd_seq.sv
module tb_ddr2_cal_rd_seq;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cal_start = 1'b0;
    logic       comp_done = 1'b0;
    logic       comp_error = 1'b0;
    logic       cal_first_loop = 1'b1;
    logic       user_rden = 1'b0;
    logic       ctrl_rden;
    logic       user_rd_gnt;
    logic       cal_busy;
    logic       cal_ok;
    logic       cal_fail;
    logic [1:0] attempt_cnt;
    logic [2:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];   // required ctrl_rden run lengths, in order
    int run_len = 0;

    ddr2_cal_rd_seq #(
        .BURST_LEN(2),
        .RD_GAP(32),
        .MAX_ATTEMPTS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cal_start(cal_start),
        .comp_done(comp_done),
        .comp_error(comp_error),
        .cal_first_loop(cal_first_loop),
        .user_rden(user_rden),
        .ctrl_rden(ctrl_rden),
        .user_rd_gnt(user_rd_gnt),
        .cal_busy(cal_busy),
        .cal_ok(cal_ok),
        .cal_fail(cal_fail),
        .attempt_cnt(attempt_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: measures each ctrl_rden run and pops the
    // expected length pushed when the stimulus was driven.
    always @(negedge clk) begin
        int e;
        if (ctrl_rden === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL burst_len: unexpected ctrl_rden run of %0d cycles, none required", run_len);
            end else begin
                e = exp_q.pop_front();
                if (run_len !== e) begin
                    miscompares++;
                    $display("FAIL burst_len: ctrl_rden run %0d cycles, required %0d", run_len, e);
                end
            end
            run_len = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_fall(input string tag);
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ctrl_rden === 1'b1) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_burst: no ctrl_rden burst end within 200 cycles, required one", tag);
        end
    endtask

    task automatic count_state(input logic [2:0] st, output int n);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dbg_state === st) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        bit bad;
        user_rden = 1'b1;
        repeat (3) cyc();
        smp();
        vectors++;
        if ({dbg_state, ctrl_rden, user_rd_gnt, cal_busy, cal_ok, cal_fail, attempt_cnt} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d rden=%b gnt=%b busy=%b ok=%b fail=%b att=%0d, required all 0",
                     dbg_state, ctrl_rden, user_rd_gnt, cal_busy, cal_ok, cal_fail, attempt_cnt);
        end
        cyc();
        reset = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            smp();
            if (dbg_state !== S_IDLE || user_rd_gnt !== 1'b0 || ctrl_rden !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_idle: activity seen after reset without cal_start (state=%0d gnt=%b), required idle",
                     dbg_state, user_rd_gnt);
        end
        cyc();
        user_rden = 1'b0;
    endtask

    task automatic test_single_read();
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        cyc();
        cal_start = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, cal_busy, attempt_cnt, ctrl_rden} !== {S_ISSUE, 1'b1, 2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_issue: state=%0d busy=%b att=%0d rden=%b, required 1 1 1 0",
                     dbg_state, cal_busy, attempt_cnt, ctrl_rden);
        end
        wait_fall("single");
        vectors++;
        if (dbg_state !== S_WAIT) begin
            miscompares++;
            $display("FAIL single_wait: state=%0d, required %0d", dbg_state, S_WAIT);
        end
        cyc();
        cal_start = 1'b1;
        cyc();
        cal_start = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, attempt_cnt} !== {S_WAIT, 2'd1}) begin
            miscompares++;
            $display("FAIL busy_ignore: state=%0d att=%0d, required 2 1", dbg_state, attempt_cnt);
        end
        repeat (7) cyc();
        cyc();
        comp_done = 1'b1;
        cyc();
        comp_done = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, cal_ok, cal_busy, cal_fail, attempt_cnt} !== {S_DONE, 1'b1, 1'b0, 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL single_done: state=%0d ok=%b busy=%b fail=%b att=%0d, required 4 1 0 0 1",
                     dbg_state, cal_ok, cal_busy, cal_fail, attempt_cnt);
        end
    endtask

    task automatic test_second_read();
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        cyc();
        cal_start = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, attempt_cnt} !== {S_ISSUE, 2'd1}) begin
            miscompares++;
            $display("FAIL restart_done: state=%0d att=%0d, required 1 1", dbg_state, attempt_cnt);
        end
        wait_fall("second_a");
        cyc();
        cyc();
        cal_first_loop = 1'b0;
        exp_q.push_back(2);
        cyc();
        cal_first_loop = 1'b1;
        smp();
        vectors++;
        if ({dbg_state, attempt_cnt} !== {S_ISSUE, 2'd2}) begin
            miscompares++;
            $display("FAIL second_issue: state=%0d att=%0d, required 1 2", dbg_state, attempt_cnt);
        end
        wait_fall("second_b");
        cyc();
        cyc();
        comp_done = 1'b1;
        cyc();
        comp_done = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, cal_ok, attempt_cnt} !== {S_DONE, 1'b1, 2'd2}) begin
            miscompares++;
            $display("FAIL second_done: state=%0d ok=%b att=%0d, required 4 1 2", dbg_state, cal_ok, attempt_cnt);
        end
    endtask

    task automatic test_fail_timeout();
        int n;
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(2);
        cyc();
        cal_start = 1'b0;
        wait_fall("timeout_a");
        count_state(S_WAIT, n);
        vectors++;
        if (n !== 32 || dbg_state !== S_CHECK) begin
            miscompares++;
            $display("FAIL timeout_wait1: wait cycles=%0d then state=%0d, required 32 then 3", n, dbg_state);
        end
        smp();
        vectors++;
        if ({dbg_state, attempt_cnt} !== {S_ISSUE, 2'd2}) begin
            miscompares++;
            $display("FAIL timeout_retry: state=%0d att=%0d, required 1 2", dbg_state, attempt_cnt);
        end
        wait_fall("timeout_b");
        count_state(S_WAIT, n);
        vectors++;
        if (n !== 32 || dbg_state !== S_CHECK) begin
            miscompares++;
            $display("FAIL timeout_wait2: wait cycles=%0d then state=%0d, required 32 then 3", n, dbg_state);
        end
        smp();
        vectors++;
        if ({dbg_state, cal_fail, cal_ok, cal_busy, attempt_cnt} !== {S_FAIL, 1'b1, 1'b0, 1'b0, 2'd2}) begin
            miscompares++;
            $display("FAIL timeout_fail: state=%0d fail=%b ok=%b busy=%b att=%0d, required 5 1 0 0 2",
                     dbg_state, cal_fail, cal_ok, cal_busy, attempt_cnt);
        end
    endtask

    task automatic test_error_priority();
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        cyc();
        cal_start = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, cal_fail, attempt_cnt} !== {S_ISSUE, 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL restart_fail: state=%0d fail=%b att=%0d, required 1 0 1", dbg_state, cal_fail, attempt_cnt);
        end
        wait_fall("error");
        cyc();
        comp_error = 1'b1;
        cal_first_loop = 1'b0;
        cyc();
        comp_error = 1'b0;
        cal_first_loop = 1'b1;
        smp();
        vectors++;
        if ({dbg_state, cal_fail, attempt_cnt} !== {S_FAIL, 1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL error_fail: state=%0d fail=%b att=%0d, required 5 1 1", dbg_state, cal_fail, attempt_cnt);
        end
        repeat (40) cyc();
        smp();
        vectors++;
        if (dbg_state !== S_FAIL || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL error_quiet: state=%0d pending bursts=%0d, required 5 0", dbg_state, exp_q.size());
        end
    endtask

    task automatic test_done_user_read();
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        cyc();
        cal_start = 1'b0;
        wait_fall("user_cal");
        cyc();
        comp_done = 1'b1;
        cyc();
        comp_done = 1'b0;
        smp();
        vectors++;
        if (dbg_state !== S_DONE) begin
            miscompares++;
            $display("FAIL user_done: state=%0d, required 4", dbg_state);
        end
        cyc();
        user_rden = 1'b1;
        exp_q.push_back(1);
        smp();
        vectors++;
        if ({user_rd_gnt, ctrl_rden} !== 2'b10) begin
            miscompares++;
            $display("FAIL user_gnt0: gnt=%b rden=%b, required 1 0", user_rd_gnt, ctrl_rden);
        end
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        smp();
        vectors++;
        if ({user_rd_gnt, ctrl_rden} !== 2'b01) begin
            miscompares++;
            $display("FAIL user_gnt1: gnt=%b rden=%b, required 0 1", user_rd_gnt, ctrl_rden);
        end
        cyc();
        cal_start = 1'b0;
        smp();
        vectors++;
        if ({user_rd_gnt, ctrl_rden, cal_busy, dbg_state, attempt_cnt} !== {1'b0, 1'b0, 1'b1, S_ISSUE, 2'd1}) begin
            miscompares++;
            $display("FAIL user_gnt2: gnt=%b rden=%b busy=%b state=%0d att=%0d, required 0 0 1 1 1",
                     user_rd_gnt, ctrl_rden, cal_busy, dbg_state, attempt_cnt);
        end
        cyc();
        user_rden = 1'b0;
        wait_fall("user_recal");
        cyc();
        comp_done = 1'b1;
        cyc();
        comp_done = 1'b0;
    endtask

    task automatic test_reset_midburst();
        bit bad;
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(1);
        cyc();
        cal_start = 1'b0;
        cyc();
        smp();
        vectors++;
        if (ctrl_rden !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_pre: rden=%b, required 1", ctrl_rden);
        end
        cyc();
        reset = 1'b1;
        #1;
        vectors++;
        if ({ctrl_rden, dbg_state, cal_busy, attempt_cnt, user_rd_gnt} !== 7'b0) begin
            miscompares++;
            $display("FAIL midburst_reset: rden=%b state=%0d busy=%b att=%0d gnt=%b, required all 0",
                     ctrl_rden, dbg_state, cal_busy, attempt_cnt, user_rd_gnt);
        end
        cyc();
        cyc();
        reset = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            smp();
            if (dbg_state !== S_IDLE || ctrl_rden !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL midburst_idle: activity after reset (state=%0d rden=%b), required idle", dbg_state, ctrl_rden);
        end
        cyc();
        cal_start = 1'b1;
        exp_q.push_back(2);
        cyc();
        cal_start = 1'b0;
        wait_fall("post_reset");
        cyc();
        comp_done = 1'b1;
        cyc();
        comp_done = 1'b0;
        smp();
        vectors++;
        if ({dbg_state, cal_ok, attempt_cnt} !== {S_DONE, 1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL post_reset_done: state=%0d ok=%b att=%0d, required 4 1 1", dbg_state, cal_ok, attempt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_second_read();
        test_fail_timeout();
        test_error_priority();
        test_done_user_read();
        test_reset_midburst();
        repeat (3) cyc();
        smp();
        vectors++;
        if (exp_q.size() != 0 || run_len != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: pending bursts=%0d open run=%0d, required 0 0", exp_q.size(), run_len);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr2_cal_rd_seq.md
DDR2_CAL_RD_SEQ -- requirements
Module: DDR2_cal_rd_seq

Interface
REQ-001 Parameter BURST_LEN, default 2: number of cycles ctrl_rden is held high per calibration read (range 1-15).
REQ-002 Parameter RD_GAP, default 32: cycles to wait after a calibration read for the pattern result (range 2-255).
REQ-003 Parameter MAX_ATTEMPTS, default 2: maximum calibration reads per calibration run (range 1-3).
REQ-004 clk  input  1  sole clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cal_start  input  1  single-cycle request from the init sequencer to start or restart pattern calibration.
REQ-007 comp_done  input  1  AND of all per-byte pattern-compare done flags.
REQ-008 comp_error  input  1  OR of all per-byte pattern-compare error flags.
REQ-009 cal_first_loop  input  1  goes low for one cycle when a second calibration read is required.
REQ-010 user_rden  input  1  read-enable request from the user command path.
REQ-011 ctrl_rden  output  1  registered read enable to the read-data datapath.
REQ-012 user_rd_gnt  output  1  user read accepted this cycle.
REQ-013 cal_busy, cal_ok, cal_fail  output  1 each  status flags.
REQ-014 attempt_cnt  output  2  number of calibration reads issued in the current run.
REQ-015 dbg_state  output  3  current FSM state encoding.

Function
REQ-016 The FSM SHALL have states IDLE=0, ISSUE=1, WAIT=2, CHECK=3, DONE=4 and FAIL=5.
REQ-017 IDLE: on cal_start=1 go to ISSUE, clear attempt_cnt and then set it to 1.
REQ-018 ISSUE: ctrl_rden SHALL be 1 for exactly BURST_LEN consecutive cycles, starting the cycle after ISSUE is entered; then go to WAIT and load the wait counter with RD_GAP.
REQ-019 WAIT transitions, highest priority first:
- comp_done=1 -> DONE
- comp_error=1 -> FAIL
- cal_first_loop=0 and attempt_cnt<MAX_ATTEMPTS -> ISSUE, attempt_cnt+1
- wait counter reaches 0 -> CHECK
REQ-020 CHECK lasts one cycle:
- comp_done=1 -> DONE
- otherwise attempt_cnt<MAX_ATTEMPTS -> ISSUE, attempt_cnt+1
- otherwise -> FAIL
REQ-021 attempt_cnt SHALL saturate at MAX_ATTEMPTS and never wrap.
REQ-022 cal_busy SHALL be 1 in ISSUE, WAIT and CHECK; cal_ok SHALL be 1 only in DONE; cal_fail SHALL be 1 only in FAIL.
REQ-023 DONE:
- user_rd_gnt = user_rden AND NOT cal_start (combinational).
- ctrl_rden SHALL equal user_rd_gnt delayed by one cycle.
REQ-024 Outside DONE, user_rd_gnt SHALL be 0 and user_rden SHALL be ignored.
REQ-025 cal_start=1 in DONE or FAIL SHALL restart calibration exactly as from IDLE.
- In DONE, cal_start wins over a simultaneous user_rden.
REQ-026 cal_start while cal_busy=1 SHALL be ignored.
REQ-027 ctrl_rden SHALL never be 1 in IDLE, CHECK or FAIL, except for the single trailing cycle of a granted user read.

Reset
REQ-028 Asserting reset at any time, including mid-burst, SHALL immediately force the following state:
- IDLE
- ctrl_rden=0, user_rd_gnt=0
- cal_busy=0, cal_ok=0, cal_fail=0
- attempt_cnt=0
- burst and wait counters =0
- dbg_state=0
REQ-029 After reset deasserts, the block SHALL start no calibration read until cal_start is seen.

Structure
REQ-030 The state encodings and the counter widths (4-bit burst counter, 8-bit wait counter) SHALL be defined in the shared DDR2 parameters include.
REQ-031 The block SHALL be a single module with no sub-modules; the wait and burst counters are inline down-counters.

Verification
REQ-032 Run with BURST_LEN=2 and RD_GAP=32. Pulse cal_start; raise comp_done 10 cycles after ctrl_rden falls. Required: ctrl_rden high for exactly 2 cycles, then cal_ok=1, attempt_cnt=1.
REQ-033 Drop cal_first_loop low for 1 cycle during WAIT of attempt 1; comp_done follows after the second read. Required: a second 2-cycle ctrl_rden burst, attempt_cnt=2, final cal_ok=1.
REQ-034 Never assert comp_done, with MAX_ATTEMPTS=2. Required: two bursts, each followed by 32 WAIT cycles, then CHECK, then FAIL; cal_fail=1, attempt_cnt=2.
REQ-035 Assert comp_error in WAIT simultaneously with cal_first_loop=0. Required: FAIL next cycle and no further burst.
REQ-036 In DONE, drive user_rden for 3 cycles with cal_start on the second of those cycles. Required:
- user_rd_gnt is 1,0,0
- ctrl_rden shows one granted cycle
- a new calibration burst starts and cal_busy=1
REQ-037 Assert reset on the second cycle of a burst. Required: ctrl_rden=0 and dbg_state=0 in the same cycle; no activity until the next cal_start.
